// File: rtl/addsub_exec_unit_pkg.sv
// -----------------------------------------------------------------------------
// addsub_exec_unit_pkg
// Shared definitions for the add/sub execution unit: opcodes, CDB field
// layout, the idle CDB tag and the FSM state encoding.
// -----------------------------------------------------------------------------
package addsub_exec_unit_pkg;

    // Opcodes carried in OP_Rd[2:0]; anything other than OP_SUB adds.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    // CDB word layout: {tag[3:0], data[15:0]}.
    localparam int TAG_MSB  = 19;
    localparam int TAG_LSB  = 16;
    localparam int DATA_MSB = 15;

    // Tag 0 means "no dependency" in the stations, so the idle bus carries
    // a reserved non-zero tag instead.
    localparam logic [3:0] IDLE_TAG_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_REQ   = 2'b10,
        ST_BCAST = 2'b11
    } state_e;

    // Assemble a CDB word from its tag and data fields.
    function automatic logic [TAG_MSB:0] pack_cdb(
        input logic [TAG_MSB-TAG_LSB:0] tag,
        input logic [DATA_MSB:0]        data
    );
        return {tag, data};
    endfunction

endpackage

// File: rtl/addsub_alu16.sv
// -----------------------------------------------------------------------------
// addsub_alu16
// Combinational 16-bit modular adder/subtractor. No carry or overflow is
// produced; results wrap around.
//   a_i   in  16  operand A
//   b_i   in  16  operand B
//   sub_i in  1   1: y = a - b, 0: y = a + b
//   y_o   out 16  result
// -----------------------------------------------------------------------------
module addsub_alu16
    import addsub_exec_unit_pkg::*;
(
    input  logic [DATA_MSB:0] a_i,
    input  logic [DATA_MSB:0] b_i,
    input  logic              sub_i,
    output logic [DATA_MSB:0] y_o
);

    // Select between sum and difference; widths match so the result wraps.
    always_comb begin
        y_o = 16'h0000;
        if (sub_i) begin
            y_o = a_i - b_i;
        end else begin
            y_o = a_i + b_i;
        end
    end

endmodule

// File: rtl/addsub_exec_unit.sv
// -----------------------------------------------------------------------------
// addsub_exec_unit
// Add/sub execution unit behind an add/sub reservation station. Accepts a
// dispatched instruction, computes over LAT cycles, requests the CDB and,
// once granted, broadcasts {tag, result} for one cycle together with the
// confirma pulse and the register-file write strobe.
//
// Ports
//   CLK            in   1   clock, rising edge
//   CLR            in   1   asynchronous active-high reset
//   despacho       in   1   station has operands ready (level)
//   Valor1/Valor2  in   16  operands A / B
//   OP_Rd          in   6   [5:3] Rd, [2:0] opcode
//   ID_in          in   4   issuing station tag (1..14)
//   clockInstr_in  in   10  program line of the instruction
//   cdb_grant      in   1   arbiter grant, honoured only while requesting
//   busy           out  1   unit holds an instruction
//   cdb_req        out  1   CDB request
//   CDB            out  20  [19:16] tag, [15:0] data
//   confirma       out  1   one-cycle completion pulse
//   wb_en          out  1   register-file write strobe
//   wb_rd          out  3   destination register
//   clockInstr_out out  10  program line of the broadcast instruction
//
// Parameters
//   LAT      execute cycles from accept to result ready (1..7)
//   IDLE_TAG tag shown on the CDB while not broadcasting
// -----------------------------------------------------------------------------
module addsub_exec_unit
    import addsub_exec_unit_pkg::*;
#(
    parameter int unsigned LAT      = 2,
    parameter logic [3:0]  IDLE_TAG = IDLE_TAG_DEFAULT
)(
    input  logic              CLK,
    input  logic              CLR,
    input  logic              despacho,
    input  logic [DATA_MSB:0] Valor1,
    input  logic [DATA_MSB:0] Valor2,
    input  logic [5:0]        OP_Rd,
    input  logic [3:0]        ID_in,
    input  logic [9:0]        clockInstr_in,
    input  logic              cdb_grant,
    output logic              busy,
    output logic              cdb_req,
    output logic [TAG_MSB:0]  CDB,
    output logic              confirma,
    output logic              wb_en,
    output logic [2:0]        wb_rd,
    output logic [9:0]        clockInstr_out
);

    // The counter starts at LAT-1 so that REQ is entered exactly LAT edges
    // after the accepting edge.
    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

    state_e            state_q;
    logic [DATA_MSB:0] a_q;
    logic [DATA_MSB:0] b_q;
    logic [2:0]        op_q;
    logic [2:0]        rd_q;
    logic [3:0]        tag_q;
    logic [9:0]        line_q;
    logic [2:0]        cnt_q;
    logic [DATA_MSB:0] result_q;
    logic              armed_q;

    logic              busy_q;
    logic              req_q;
    logic [TAG_MSB:0]  cdb_q;
    logic              conf_q;
    logic              wb_en_q;
    logic [2:0]        wb_rd_q;
    logic [9:0]        line_out_q;

    logic              sub_s;
    logic [DATA_MSB:0] alu_y_s;

    assign sub_s = (op_q == OP_SUB);

    addsub_alu16 u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .sub_i (sub_s),
        .y_o   (alu_y_s)
    );

    // Control FSM with all outputs registered.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q    <= ST_IDLE;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            op_q       <= 3'd0;
            rd_q       <= 3'd0;
            tag_q      <= 4'd0;
            line_q     <= 10'd0;
            cnt_q      <= 3'd0;
            result_q   <= 16'h0000;
            armed_q    <= 1'b1;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            cdb_q      <= pack_cdb(IDLE_TAG, 16'h0000);
            conf_q     <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= 3'd0;
            line_out_q <= 10'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // armed_q only re-arms after despacho has been seen low,
                    // so a station still holding despacho from the previous
                    // instruction cannot trigger a second execution.
                    if (despacho && armed_q) begin
                        a_q     <= Valor1;
                        b_q     <= Valor2;
                        op_q    <= OP_Rd[2:0];
                        rd_q    <= OP_Rd[5:3];
                        tag_q   <= ID_in;
                        line_q  <= clockInstr_in;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        armed_q <= 1'b0;
                        state_q <= ST_EXEC;
                    end else if (!despacho) begin
                        armed_q <= 1'b1;
                    end else begin
                        armed_q <= armed_q;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 3'd0) begin
                        result_q <= alu_y_s;
                        req_q    <= 1'b1;
                        state_q  <= ST_REQ;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_REQ: begin
                    // result_q stays untouched here, so a withheld grant
                    // simply stalls with a stable result.
                    if (cdb_grant) begin
                        cdb_q      <= pack_cdb(tag_q, result_q);
                        conf_q     <= 1'b1;
                        wb_en_q    <= 1'b1;
                        wb_rd_q    <= rd_q;
                        line_out_q <= line_q;
                        req_q      <= 1'b0;
                        state_q    <= ST_BCAST;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                ST_BCAST: begin
                    cdb_q   <= pack_cdb(IDLE_TAG, 16'h0000);
                    conf_q  <= 1'b0;
                    wb_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                    conf_q  <= 1'b0;
                    wb_en_q <= 1'b0;
                    cdb_q   <= pack_cdb(IDLE_TAG, 16'h0000);
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign cdb_req        = req_q;
    assign CDB            = cdb_q;
    assign confirma       = conf_q;
    assign wb_en          = wb_en_q;
    assign wb_rd          = wb_rd_q;
    assign clockInstr_out = line_out_q;

endmodule

// File: tb/tb_addsub_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_addsub_exec_unit
// Self-checking bench for addsub_exec_unit (LAT=2). A scoreboard of expected
// broadcasts is filled as instructions are dispatched and drained by a
// per-cycle monitor; directed sequences pin timing and literal CDB words.
// -----------------------------------------------------------------------------
module tb_addsub_exec_unit;

    localparam int LAT = 2;

    typedef struct packed {
        logic [19:0] cdb;
        logic [2:0]  rd;
        logic [9:0]  line;
    } exp_t;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        despacho = 1'b0;
    logic [15:0] Valor1 = 16'h0000;
    logic [15:0] Valor2 = 16'h0000;
    logic [5:0]  OP_Rd = 6'd0;
    logic [3:0]  ID_in = 4'd0;
    logic [9:0]  clockInstr_in = 10'd0;
    logic        cdb_grant = 1'b1;
    logic        busy;
    logic        cdb_req;
    logic [19:0] CDB;
    logic        confirma;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [9:0]  clockInstr_out;

    int   tests = 0;
    int   fails = 0;
    int   bcast_cnt = 0;
    int   b0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [19:0] seen;

    addsub_exec_unit #(.LAT(LAT), .IDLE_TAG(4'hF)) dut (
        .CLK            (CLK),
        .CLR            (CLR),
        .despacho       (despacho),
        .Valor1         (Valor1),
        .Valor2         (Valor2),
        .OP_Rd          (OP_Rd),
        .ID_in          (ID_in),
        .clockInstr_in  (clockInstr_in),
        .cdb_grant      (cdb_grant),
        .busy           (busy),
        .cdb_req        (cdb_req),
        .CDB            (CDB),
        .confirma       (confirma),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .clockInstr_out (clockInstr_out)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result: 16-bit wrap-around add, or subtract for opcode 1.
    function automatic logic [15:0] model_result(input logic [15:0] a, input logic [15:0] b,
                                                  input logic [2:0] op);
        int r;
        if (op == 3'b001) r = int'(a) - int'(b);
        else              r = int'(a) + int'(b);
        return r[15:0];
    endfunction

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic dispatch(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                            input logic [2:0] rd, input logic [3:0] id, input logic [9:0] line,
                            input bit expect_bcast);
        exp_t e;
        Valor1        = a;
        Valor2        = b;
        OP_Rd         = {rd, op};
        ID_in         = id;
        clockInstr_in = line;
        despacho      = 1'b1;
        if (expect_bcast) begin
            e.cdb  = {id, model_result(a, b, op)};
            e.rd   = rd;
            e.line = line;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_conf(output logic [19:0] c);
        c = 20'h0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (confirma) begin
                c = CDB;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL confirma_timeout: no confirma within 60 cycles, required one");
    endtask

    // Station drops despacho on the edge that samples confirma.
    task automatic release_station();
        tick();
        despacho = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tagname);
        check({tagname, "_busy"}, busy, 1'b0);
        check({tagname, "_req"}, cdb_req, 1'b0);
        check({tagname, "_conf"}, confirma, 1'b0);
        check({tagname, "_wben"}, wb_en, 1'b0);
        check({tagname, "_wbrd"}, wb_rd, 3'd0);
        check({tagname, "_line"}, clockInstr_out, 10'd0);
        check({tagname, "_cdb"}, CDB, 20'hF0000);
    endtask

    // Scoreboard monitor: every out-of-reset cycle the bus must be either a
    // queued broadcast or idle.
    always @(negedge CLK) begin
        if (!CLR) begin
            if (confirma) begin
                bcast_cnt++;
                check("bcast_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("mon_cdb", CDB, mon_e.cdb);
                    check("mon_wb_rd", wb_rd, mon_e.rd);
                    check("mon_line", clockInstr_out, mon_e.line);
                    check("mon_wb_en", wb_en, 1'b1);
                    check("mon_req_low", cdb_req, 1'b0);
                end
            end else begin
                check("mon_cdb_idle", CDB, 20'hF0000);
                check("mon_wb_en_idle", wb_en, 1'b0);
            end
            if (cdb_req) check("mon_req_busy", busy, 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        check_reset_outputs("rst");
        CLR = 1'b0;
        tick();
        check_reset_outputs("post_rst");

        // Basic ADD 5+3, ID 1, Rd 2, grant held: hand-computed timeline
        dispatch(16'd5, 16'd3, 3'b000, 3'd2, 4'd1, 10'd17, 1'b1);
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            check("basic_req", cdb_req, k == LAT + 1);
            check("basic_conf", confirma, k == LAT + 2);
            check("basic_busy", busy, k <= LAT + 2);
            if (k == LAT + 2) begin
                check("basic_cdb", CDB, 20'h10008);
                check("basic_wbrd", wb_rd, 3'd2);
                check("basic_line", clockInstr_out, 10'd17);
            end
            if (k == LAT + 3) begin
                check("basic_cdb_idle", CDB, 20'hF0000);
                despacho = 1'b0;
            end
        end
        tick();

        // SUB wrap 0-1, ID 3
        dispatch(16'h0000, 16'h0001, 3'b001, 3'd3, 4'd3, 10'd5, 1'b1);
        wait_conf(seen);
        check("sub_wrap", seen, 20'h3FFFF);
        release_station();
        tick();

        // ADD wrap FFFF+1 with a non-SUB opcode, ID 2
        dispatch(16'hFFFF, 16'h0001, 3'b101, 3'd4, 4'd2, 10'd6, 1'b1);
        wait_conf(seen);
        check("add_wrap", seen, 20'h20000);
        release_station();
        tick();

        // Grant stall
        b0 = bcast_cnt;
        cdb_grant = 1'b0;
        dispatch(16'h1000, 16'h0234, 3'b000, 3'd5, 4'd4, 10'd100, 1'b1);
        for (int k = 0; k < 20 && !cdb_req; k++) tick();
        check("stall_req_seen", cdb_req, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_req", cdb_req, 1'b1);
            check("stall_busy", busy, 1'b1);
            check("stall_conf", confirma, 1'b0);
        end
        cdb_grant = 1'b1;
        tick();
        check("stall_conf_pulse", confirma, 1'b1);
        check("stall_cdb", CDB, 20'h41234);
        tick();
        check("stall_conf_end", confirma, 1'b0);
        despacho = 1'b0;
        tick();
        check("stall_bcast_count", bcast_cnt - b0, 1);

        // Back-to-back via station model
        b0 = bcast_cnt;
        dispatch(16'd100, 16'd50, 3'b001, 3'd6, 4'd5, 10'd200, 1'b1);
        wait_conf(seen);
        check("b2b_first", seen, 20'h50032);
        release_station();
        tick();
        dispatch(16'd7, 16'd8, 3'b000, 3'd7, 4'd6, 10'd201, 1'b1);
        wait_conf(seen);
        check("b2b_second", seen, 20'h6000F);
        release_station();
        repeat (4) tick();
        check("b2b_bcast_count", bcast_cnt - b0, 2);
        check("b2b_queue_empty", exp_q.size(), 0);

        // despacho held high after completion must not re-execute
        b0 = bcast_cnt;
        dispatch(16'd2, 16'd2, 3'b000, 3'd1, 4'd7, 10'd300, 1'b1);
        wait_conf(seen);
        check("hold_cdb", seen, 20'h70004);
        repeat (8) tick();
        check("hold_busy", busy, 1'b0);
        despacho = 1'b0;
        tick();
        check("hold_bcast_count", bcast_cnt - b0, 1);

        // Asynchronous reset during EXEC
        dispatch(16'd9, 16'd9, 3'b000, 3'd2, 4'd8, 10'd400, 1'b0);
        @(posedge CLK);
        #2;
        check("rst_exec_pre_busy", busy, 1'b1);
        CLR = 1'b1;
        #1;
        check_reset_outputs("rst_exec");
        despacho = 1'b0;
        tick();
        tick();
        CLR = 1'b0;
        b0 = bcast_cnt;
        repeat (8) tick();
        check("rst_exec_no_bcast", bcast_cnt - b0, 0);
        check("rst_exec_idle_busy", busy, 1'b0);
        dispatch(16'd100, 16'd23, 3'b000, 3'd3, 4'd8, 10'd401, 1'b1);
        wait_conf(seen);
        check("rst_exec_after", seen, 20'h8007B);
        release_station();
        tick();

        // despacho/ID changed while busy is ignored
        b0 = bcast_cnt;
        dispatch(16'h00AA, 16'h0055, 3'b000, 3'd5, 4'd9, 10'd500, 1'b1);
        tick();
        Valor1   = 16'h1111;
        ID_in    = 4'd10;
        despacho = 1'b0;
        tick();
        despacho = 1'b1;
        wait_conf(seen);
        check("busy_ignore_cdb", seen, 20'h900FF);
        release_station();
        repeat (4) tick();
        check("busy_ignore_count", bcast_cnt - b0, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/addsub_exec_unit.md
Name: addsub_exec_unit

Overview:
Add/sub arithmetic unit that receives the dispatch side of an add/sub reservation station: despacho, Valor1/Valor2, OP_Rd, ID and instruction line number. It computes the result over a fixed, parameterised latency and requests the common data bus (CDB). When granted, it broadcasts {tag, result} for one cycle and pulses confirma in that same cycle, which releases the station. It sits between the reservation stations, the CDB arbiter and the register-file write port.

Parameters:
LAT, 2, execute cycles from accept to result ready (1..7)
IDLE_TAG, 4'hF, tag driven on CDB when not broadcasting; reserved, never used as a station ID

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  asynchronous active-high reset
despacho  in  1  station has operands ready (level; held until confirma seen)
Valor1  in  16  operand A
Valor2  in  16  operand B
OP_Rd  in  6  [5:3] Rd, [2:0] opcode
ID_in  in  4  issuing station tag
clockInstr_in  in  10  program line of instruction
cdb_grant  in  1  arbiter grant, sampled while cdb_req=1
busy  out  1  unit holds an instruction
cdb_req  out  1  request for CDB
CDB  out  20  [19:16] tag, [15:0] data
confirma  out  1  one-cycle completion pulse to station
wb_en  out  1  register-file write strobe (same cycle as broadcast)
wb_rd  out  3  destination register
clockInstr_out  out  10  program line of the broadcast instruction

Behaviour:
- Reset (async, CLR=1): state=IDLE; busy=0, cdb_req=0, confirma=0, wb_en=0, wb_rd=0, clockInstr_out=0, CDB={IDLE_TAG,16'h0}; internal counters/latches cleared. Reset mid-operation aborts the instruction with no broadcast.
- All outputs are registered.
- FSM states: IDLE, EXEC, REQ, BCAST.
- IDLE: on an edge with despacho=1, latch A, B, op, Rd, tag, line; cnt=LAT-1; busy=1; next state EXEC.
- EXEC: cnt decrements each edge. When cnt==0, result is latched and the FSM enters REQ with cdb_req=1. Accept-to-REQ is exactly LAT edges.
- Opcode 3'b001 = SUB (A-B); every other opcode = ADD (A+B). 16-bit modular arithmetic: wrap-around, no carry or overflow output. E.g. 16'hFFFF+1=16'h0000 and 0-1=16'hFFFF.
- REQ: hold cdb_req=1 until cdb_grant=1 at an edge. At that edge, enter BCAST and set CDB={tag,result}, confirma=1, wb_en=1, wb_rd=Rd, clockInstr_out=line, cdb_req=0.
- BCAST lasts exactly one cycle. Next edge: CDB={IDLE_TAG,0}, confirma=0, wb_en=0, busy=0, state=IDLE.
- Re-accept guard: the station drops despacho on the edge that samples confirma, so at the first IDLE edge despacho is already 0. The unit additionally requires despacho to have been sampled 0 at least once after BCAST before accepting again, which prevents double-execution.
- despacho while busy: ignored.
- cdb_grant outside REQ: ignored.
- Grant withheld indefinitely: the unit stalls in REQ with the result held stable.
- Idle CDB tag is IDLE_TAG, never 0, because tag 0 means "no dependency" in the stations.
- ID_in is forwarded unchanged. Legal station IDs are 1..14.

Decomposition:
- Shared package holds: OP_ADD=3'b000, OP_SUB=3'b001, CDB field positions (TAG_MSB=19, TAG_LSB=16, DATA_MSB=15), IDLE_TAG, and FSM state encodings.
- One natural sub-module: addsub_alu16, combinational (a, b, sub -> y).

Test Plan:
- Basic ADD, LAT=2: Valor1=5, Valor2=3, OP_Rd={3'd2,3'b000}, ID=1; grant held 1. cdb_req rises 2 edges after accept. Next cycle: CDB=20'h1_0008, confirma=1, wb_rd=2 for one cycle, then CDB=20'hF_0000.
- SUB wrap: 0-1 with ID=3 -> CDB=20'h3_FFFF. ADD wrap: 16'hFFFF+1 -> data 16'h0000.
- Grant stall: withhold grant 5 cycles. cdb_req stays 1, busy=1, no confirma. Grant on the 6th cycle -> exactly one broadcast cycle.
- Back-to-back: a station model drops despacho after confirma and re-asserts with a new op one cycle later. Exactly two broadcasts occur, with no duplicate of the first.
- Reset mid-EXEC: assert CLR asynchronously (between edges) during EXEC. All outputs go to reset values immediately; no confirma or broadcast follows; a new dispatch works normally.
- despacho pulsed while busy with a different ID -> ignored. Only the original tag is broadcast.
